fma_vector_checker: RTL and testbench

//  Synthesisable self-checking vector sequencer for FMA units.
//  - Fetches packed vectors {x,y,z,ctrl,rexp,fexp} from a synchronous vector ROM.
//  - Drives the operands to a DUT with arbitrary pipeline latency and compares the result.
//  - Counts mismatches and reports each one.
//  - Successor to the simulation-only fma16 bench: any FLEN, any DUT latency, FPGA/emulation use.

---
 rtl/fma_check_pkg.sv | 56 +++++
 rtl/fma_check_delay.sv | 48 ++++
 rtl/fma_vector_checker.sv | 190 +++++++++++++++++++
 tb/tb_fma_vector_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_check_pkg.sv
// Shared definitions for the FMA vector checker.
//  - ctrl byte field offsets and flag bit indices
//  - checker FSM state type
//  - unpack_vec: splits a packed test vector {x,y,z,ctrl,rexp,fexp} (x in MSBs)
//    into fields. The vector is passed zero-extended to VW_MAX bits together
//    with the real FLEN/NF so one function serves every build width.
package fma_check_pkg;

  localparam int unsigned CTRL_RM_LO = 4;   // roundmode = ctrl[5:4]
  localparam int unsigned CTRL_MUL   = 3;
  localparam int unsigned CTRL_ADD   = 2;
  localparam int unsigned CTRL_NEGP  = 1;
  localparam int unsigned CTRL_NEGZ  = 0;

  localparam int unsigned FLG_NV = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam int unsigned FLEN_MAX = 64;
  localparam int unsigned NF_MAX   = 8;
  localparam int unsigned VW_MAX   = 4*FLEN_MAX + 8 + NF_MAX;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [FLEN_MAX-1:0] x;
    logic [FLEN_MAX-1:0] y;
    logic [FLEN_MAX-1:0] z;
    logic [7:0]          ctrl;
    logic [FLEN_MAX-1:0] rexp;
    logic [NF_MAX-1:0]   fexp;
  } vec_t;

  function automatic vec_t unpack_vec(input logic [VW_MAX-1:0] v,
                                      input int unsigned flen,
                                      input int unsigned nf);
    vec_t u;
    logic [VW_MAX-1:0] s;
    u = '0;
    s = v;
    for (int unsigned b = 0; b < NF_MAX; b++) if (b < nf) u.fexp[b] = s[b];
    s = s >> nf;
    for (int unsigned b = 0; b < FLEN_MAX; b++) if (b < flen) u.rexp[b] = s[b];
    s = s >> flen;
    u.ctrl = s[7:0];
    s = s >> 8;
    for (int unsigned b = 0; b < FLEN_MAX; b++) if (b < flen) u.z[b] = s[b];
    s = s >> flen;
    for (int unsigned b = 0; b < FLEN_MAX; b++) if (b < flen) u.y[b] = s[b];
    s = s >> flen;
    for (int unsigned b = 0; b < FLEN_MAX; b++) if (b < flen) u.x[b] = s[b];
    return u;
  endfunction

endpackage

// File: rtl/fma_check_delay.sv
// Valid + payload shift register, LAT stages deep (LAT=0 is a wire).
// Aligns the expected result/flags/index with the DUT's pipeline latency.
// Ports:
//  clk, reset (sync, active-low)
//  vld_in, din[W]   entry into the delay line
//  vld_out, dout[W] same entry LAT cycles later
module fma_check_delay #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld_in,
  input  logic [W-1:0] din,
  output logic         vld_out,
  output logic [W-1:0] dout
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ports;
      assign unused_ports = clk ^ reset;
      assign vld_out = vld_in;
      assign dout    = din;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [W-1:0]   dat_q [LAT];

      always_ff @(posedge clk) begin
        if (!reset) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= vld_in;
          dat_q[0] <= din;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign vld_out = vld_q[LAT-1];
      assign dout    = dat_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fma_vector_checker.sv
// Self-checking vector sequencer for FMA units. Reads packed vectors from an
// external synchronous ROM, drives registered operands to an external DUT of
// latency LAT and compares the DUT result (and optionally flags) bit-exactly.
// Build option: define FMA_CHECK_FLAGS_EN to also compare DUT flags with fexp.
// Ports:
//  clk, reset (sync, active-low)      start, num_vec  run control
//  vec_addr / vec_data                ROM read port (data 1 cycle after addr)
//  x,y,z,roundmode,mul,add,negp,negz  DUT operands, registered
//  result, flags                      DUT outputs
//  busy, done                         run status
//  errors, checked                    mismatch count (saturating), compare count
//  err_valid, err_index, err_result   per-mismatch report, 1-cycle pulse
//
// state | meaning
// IDLE  | after reset, waiting for start
// ISSUE | one ROM address per cycle, 0..num_vec-1
// DRAIN | last address issued, letting LAT+2 cycles of pipe empty
// DONE  | run finished, counters stable, waiting for start
module fma_vector_checker
  import fma_check_pkg::*;
#(
  parameter  int unsigned FLEN  = 16,
  parameter  int unsigned NF    = 4,
  parameter  int unsigned DEPTH = 1024,
  parameter  int unsigned LAT   = 0,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned VW    = 4*FLEN + 8 + NF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW:0]     num_vec,
  output logic [AW-1:0]   vec_addr,
  input  logic [VW-1:0]   vec_data,
  output logic [FLEN-1:0] x,
  output logic [FLEN-1:0] y,
  output logic [FLEN-1:0] z,
  output logic [1:0]      roundmode,
  output logic            mul,
  output logic            add,
  output logic            negp,
  output logic            negz,
  input  logic [FLEN-1:0] result,
  input  logic [NF-1:0]   flags,
  output logic            busy,
  output logic            done,
  output logic [31:0]     errors,
  output logic [31:0]     checked,
  output logic            err_valid,
  output logic [AW-1:0]   err_index,
  output logic [FLEN-1:0] err_result
);

  localparam int unsigned DW = $clog2(LAT + 2);
`ifdef FMA_CHECK_FLAGS_EN
  localparam int unsigned PW = FLEN + NF + AW;
`else
  localparam int unsigned PW = FLEN + AW;
`endif

  state_t          state, state_nxt;
  logic [AW:0]     nv_q;
  logic [DW-1:0]   drain_cnt;
  logic            start_acc, issue, last_issue;
  logic            vld_b, vld_c, vld_d;
  logic [AW-1:0]   idx_b, idx_d;
  logic [PW-1:0]   exp_c, exp_d;
  logic [FLEN-1:0] rexp_d;
  logic            mis;
  vec_t            vec_f;

  assign vec_f      = unpack_vec(VW_MAX'(vec_data), FLEN, NF);
  assign start_acc  = start && (state == IDLE || state == DONE);
  assign issue      = (state == ISSUE);
  assign last_issue = issue && (({1'b0, vec_addr} + (AW+1)'(1)) == nv_q);
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (num_vec == '0) ? DONE : ISSUE;
      ISSUE:      if (last_issue) state_nxt = DRAIN;
      DRAIN:      if (drain_cnt == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Expected values travel alongside the operands: rexp/fexp/index are
  // captured with the operands and delayed by LAT to meet the DUT result.
`ifdef FMA_CHECK_FLAGS_EN
  logic [NF-1:0] fexp_d;
  logic          unused_bits;
  assign unused_bits = ^vec_f;
  assign {rexp_d, fexp_d, idx_d} = exp_d;
  assign mis = (result != rexp_d) || (flags != fexp_d);
`else
  logic unused_bits;
  assign unused_bits = ^{vec_f, flags, exp_c[0]};
  assign {rexp_d, idx_d} = exp_d;
  assign mis = (result != rexp_d);
`endif

  fma_check_delay #(.W(PW), .LAT(LAT)) u_delay (
    .clk     (clk),
    .reset   (reset),
    .vld_in  (vld_c),
    .din     (exp_c),
    .vld_out (vld_d),
    .dout    (exp_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      vec_addr   <= '0;
      nv_q       <= '0;
      drain_cnt  <= '0;
      vld_b      <= 1'b0;
      idx_b      <= '0;
      vld_c      <= 1'b0;
      exp_c      <= '0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      roundmode  <= '0;
      mul        <= 1'b0;
      add        <= 1'b0;
      negp       <= 1'b0;
      negz       <= 1'b0;
      errors     <= '0;
      checked    <= '0;
      err_valid  <= 1'b0;
      err_index  <= '0;
      err_result <= '0;
    end else begin
      if (start_acc) begin
        vec_addr <= '0;
        nv_q     <= num_vec;
      end else if (issue && !last_issue) begin
        vec_addr <= vec_addr + AW'(1);
      end

      if (last_issue)
        drain_cnt <= DW'(LAT + 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);

      vld_b <= issue;
      idx_b <= vec_addr;
      vld_c <= vld_b;

      // Operands hold their last value once issue stops.
      if (vld_b) begin
        x         <= vec_f.x[FLEN-1:0];
        y         <= vec_f.y[FLEN-1:0];
        z         <= vec_f.z[FLEN-1:0];
        roundmode <= vec_f.ctrl[CTRL_RM_LO +: 2];
        mul       <= vec_f.ctrl[CTRL_MUL];
        add       <= vec_f.ctrl[CTRL_ADD];
        negp      <= vec_f.ctrl[CTRL_NEGP];
        negz      <= vec_f.ctrl[CTRL_NEGZ];
`ifdef FMA_CHECK_FLAGS_EN
        exp_c     <= {vec_f.rexp[FLEN-1:0], vec_f.fexp[NF-1:0], idx_b};
`else
        exp_c     <= {vec_f.rexp[FLEN-1:0], idx_b};
`endif
      end

      err_valid <= 1'b0;
      if (start_acc) begin
        errors  <= '0;
        checked <= '0;
      end else if (vld_d) begin
        checked <= checked + 32'd1;
        if (mis) begin
          if (errors != '1) errors <= errors + 32'd1;
          err_valid  <= 1'b1;
          err_index  <= idx_d;
          err_result <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_fma_vector_checker.sv
// Directed bench for fma_vector_checker: one checker with a combinational
// toy DUT (LAT=0) and one with a 3-cycle toy DUT (LAT=3), sharing one ROM.
// Toy DUT: result = x ^ y ^ z ^ 16'h3c00, flags = 0.
module tb_fma_vector_checker;
  import fma_check_pkg::*;

  localparam int FLEN = 16, NF = 4, DEPTH = 1024, AW = 10;
  localparam int VW = 4*FLEN + 8 + NF;
`ifdef FMA_CHECK_FLAGS_EN
  localparam int FLAG_ERRS = 1;
`else
  localparam int FLAG_ERRS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [VW-1:0] rom [DEPTH];

  logic            start0, start3;
  logic [AW:0]     num0, num3;
  logic [AW-1:0]   addr0, addr3, ei0, ei3;
  logic [VW-1:0]   data0, data3;
  logic [FLEN-1:0] x0, y0, z0, res0, er0, x3, y3, z3, res3, er3;
  logic [1:0]      rm0, rm3;
  logic            mul0, add0, negp0, negz0, mul3, add3, negp3, negz3;
  logic [NF-1:0]   flg0, flg3;
  logic            busy0, done0, ev0, busy3, done3, ev3;
  logic [31:0]     errs0, chk0, errs3, chk3;
  logic [FLEN-1:0] p1, p2, p3;

  always @(posedge clk) begin
    data0 <= rom[addr0];
    data3 <= rom[addr3];
    p1 <= x3 ^ y3 ^ z3 ^ 16'h3c00;
    p2 <= p1;
    p3 <= p2;
  end
  assign res0 = x0 ^ y0 ^ z0 ^ 16'h3c00;
  assign flg0 = '0;
  assign res3 = p3;
  assign flg3 = '0;

  fma_vector_checker #(.FLEN(FLEN), .NF(NF), .DEPTH(DEPTH), .LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .num_vec(num0),
    .vec_addr(addr0), .vec_data(data0), .x(x0), .y(y0), .z(z0),
    .roundmode(rm0), .mul(mul0), .add(add0), .negp(negp0), .negz(negz0),
    .result(res0), .flags(flg0), .busy(busy0), .done(done0),
    .errors(errs0), .checked(chk0), .err_valid(ev0), .err_index(ei0),
    .err_result(er0));

  fma_vector_checker #(.FLEN(FLEN), .NF(NF), .DEPTH(DEPTH), .LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .num_vec(num3),
    .vec_addr(addr3), .vec_data(data3), .x(x3), .y(y3), .z(z3),
    .roundmode(rm3), .mul(mul3), .add(add3), .negp(negp3), .negz(negz3),
    .result(res3), .flags(flg3), .busy(busy3), .done(done3),
    .errors(errs3), .checked(chk3), .err_valid(ev3), .err_index(ei3),
    .err_result(er3));

  int              ev0_cnt = 0, ev3_cnt = 0;
  logic [AW-1:0]   ev0_idx, ev3_idx;
  logic [FLEN-1:0] ev0_res;
  always @(negedge clk) begin
    if (ev0) begin ev0_cnt++; ev0_idx = ei0; ev0_res = er0; end
    if (ev3) begin ev3_cnt++; ev3_idx = ei3; end
  end

  function automatic logic [VW-1:0] mkvec(input logic [15:0] a, b, c,
                                          input logic [7:0] ctrl,
                                          input logic [15:0] rexp,
                                          input logic [3:0] fexp);
    return {a, b, c, ctrl, rexp, fexp};
  endfunction

  task automatic fill_good(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a, b, c;
      a = 16'h1000 + 16'(i);
      b = 16'h2000 + 16'(3*i);
      c = 16'(7*i);
      rom[i] = mkvec(a, b, c, 8'h08, a ^ b ^ c ^ 16'h3c00, 4'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and counts edges until done is seen.
  task automatic run(input bit lat3, input int n, output int cyc);
    if (lat3) begin num3 = n[AW:0]; start3 = 1'b1; end
    else      begin num0 = n[AW:0]; start0 = 1'b1; end
    tick();
    start0 = 1'b0;
    start3 = 1'b0;
    cyc = 1;
    while (!(lat3 ? done3 : done0) && cyc < 2000) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (!(lat3 ? done3 : done0)) begin
      n_fail++;
      $display("FAIL run_timeout: done=0 after %0d cycles, required 1", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({busy0, done0, ev0, busy3, done3} !== 5'b0) begin
      n_fail++; $display("FAIL reset_status: got %b required 00000", {busy0, done0, ev0, busy3, done3});
    end
    n_tests++;
    if ({errs0, chk0} !== 64'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0h/%0h required 0/0", errs0, chk0);
    end
    n_tests++;
    if ({addr0, x0, y0, z0, rm0, mul0, add0, negp0, negz0} !== '0) begin
      n_fail++; $display("FAIL reset_operands: addr=%0h x=%0h required 0", addr0, x0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    rom[0] = mkvec(16'h3c00, 16'h3c00, 16'h0000, 8'h08, 16'h3c00, 4'h0);
    run(1'b0, 1, cyc);
    n_tests++;
    if (cyc !== 4) begin n_fail++; $display("FAIL single_latency: got %0d required 4", cyc); end
    n_tests++;
    if (errs0 !== 32'd0 || chk0 !== 32'd1) begin
      n_fail++; $display("FAIL single_counts: errors=%0d checked=%0d required 0/1", errs0, chk0);
    end
    n_tests++;
    if ({x0, y0, z0} !== {16'h3c00, 16'h3c00, 16'h0000}) begin
      n_fail++; $display("FAIL single_operands: got %0h %0h %0h required 3c00 3c00 0", x0, y0, z0);
    end
    n_tests++;
    if ({rm0, mul0, add0, negp0, negz0} !== 6'b001000) begin
      n_fail++; $display("FAIL single_ctrl: got %b required 001000", {rm0, mul0, add0, negp0, negz0});
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    fill_good(8);
    rom[5] = mkvec(16'h3c00, 16'h3c00, 16'h0000, 8'h08, 16'h4000, 4'h0);
    ev0_cnt = 0;
    run(1'b0, 8, cyc);
    tick();
    n_tests++;
    if (cyc !== 11) begin n_fail++; $display("FAIL mism_latency: got %0d required 11", cyc); end
    n_tests++;
    if (ev0_cnt !== 1) begin n_fail++; $display("FAIL mism_pulses: got %0d required 1", ev0_cnt); end
    n_tests++;
    if (ev0_idx !== 10'd5) begin n_fail++; $display("FAIL mism_index: got %0d required 5", ev0_idx); end
    n_tests++;
    if (ev0_res !== 16'h3c00) begin n_fail++; $display("FAIL mism_result: got %0h required 3c00", ev0_res); end
    n_tests++;
    if (errs0 !== 32'd1 || chk0 !== 32'd8) begin
      n_fail++; $display("FAIL mism_counts: errors=%0d checked=%0d required 1/8", errs0, chk0);
    end
  endtask

  task automatic test_latency3();
    int cyc;
    fill_good(100);
    ev3_cnt = 0;
    run(1'b1, 100, cyc);
    tick();
    n_tests++;
    if (cyc !== 106) begin n_fail++; $display("FAIL lat3_latency: got %0d required 106", cyc); end
    n_tests++;
    if (errs3 !== 32'd0 || chk3 !== 32'd100 || ev3_cnt !== 0) begin
      n_fail++; $display("FAIL lat3_counts: errors=%0d checked=%0d pulses=%0d required 0/100/0", errs3, chk3, ev3_cnt);
    end
    // Bad last vector: its mismatch must already be counted when done rises.
    rom[99][NF] = ~rom[99][NF];
    run(1'b1, 100, cyc);
    n_tests++;
    if (errs3 !== 32'd1 || chk3 !== 32'd100) begin
      n_fail++; $display("FAIL lat3_last_err: errors=%0d checked=%0d required 1/100", errs3, chk3);
    end
    tick();
    n_tests++;
    if (ev3_cnt !== 1 || ev3_idx !== 10'd99) begin
      n_fail++; $display("FAIL lat3_last_idx: pulses=%0d index=%0d required 1/99", ev3_cnt, ev3_idx);
    end
  endtask

  task automatic test_flags();
    int cyc;
    logic [3:0] fx;
    fx = '0;
    fx[FLG_NX] = 1'b1;
    rom[0] = mkvec(16'h3c00, 16'h3c00, 16'h0000, 8'h08, 16'h3c00, fx);
    run(1'b0, 1, cyc);
    n_tests++;
    if (errs0 !== 32'(FLAG_ERRS) || chk0 !== 32'd1) begin
      n_fail++; $display("FAIL flags_errors: errors=%0d checked=%0d required %0d/1", errs0, chk0, FLAG_ERRS);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, w;
    fill_good(50);
    num0 = 11'd50;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    w = 0;
    while (addr0 !== 10'd10 && w < 100) begin tick(); w++; end
    n_tests++;
    if (addr0 !== 10'd10) begin n_fail++; $display("FAIL midrun_reach: addr=%0d required 10", addr0); end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({busy0, done0, ev0} !== 3'b000 || addr0 !== '0) begin
      n_fail++; $display("FAIL midrun_state: status=%b addr=%0d required 000/0", {busy0, done0, ev0}, addr0);
    end
    n_tests++;
    if (errs0 !== 32'd0 || chk0 !== 32'd0 || {x0, y0, z0} !== '0) begin
      n_fail++; $display("FAIL midrun_clear: errors=%0d checked=%0d x=%0h required 0", errs0, chk0, x0);
    end
    reset = 1'b1;
    tick();
    ev0_cnt = 0;
    run(1'b0, 8, cyc);
    tick();
    n_tests++;
    if (cyc !== 11 || errs0 !== 32'd0 || chk0 !== 32'd8 || ev0_cnt !== 0) begin
      n_fail++; $display("FAIL midrun_rerun: cyc=%0d errors=%0d checked=%0d required 11/0/8", cyc, errs0, chk0);
    end
  endtask

  task automatic test_zero_and_busy();
    int cyc;
    run(1'b0, 0, cyc);
    n_tests++;
    if (cyc !== 1 || chk0 !== 32'd0 || errs0 !== 32'd0) begin
      n_fail++; $display("FAIL zero_run: cyc=%0d checked=%0d required 1/0", cyc, chk0);
    end
    fill_good(20);
    num0 = 11'd20;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    repeat (5) begin tick(); cyc++; end
    num0 = 11'd3;
    start0 = 1'b1;
    tick();
    cyc++;
    start0 = 1'b0;
    n_tests++;
    if (addr0 !== 10'd6 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_addr: addr=%0d busy=%b required 6/1", addr0, busy0);
    end
    while (!done0 && cyc < 2000) begin tick(); cyc++; end
    n_tests++;
    if (cyc !== 23 || chk0 !== 32'd20 || errs0 !== 32'd0) begin
      n_fail++; $display("FAIL busy_start_run: cyc=%0d checked=%0d errors=%0d required 23/20/0", cyc, chk0, errs0);
    end
  endtask

  initial begin
    reset  = 1'b0;
    start0 = 1'b0;
    start3 = 1'b0;
    num0   = '0;
    num3   = '0;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    test_reset();
    test_single();
    test_mismatch();
    test_latency3();
    test_flags();
    test_reset_midrun();
    test_zero_and_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
